ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit_if.sv | 37 +++
 rtl/ifetch_unit.sv | 137 +++++++++++++
 tb/tb_ifetch_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// Fetch unit bundle: instruction memory port, redirect, consumer side.
// master = fetch unit, slave = memory / pipeline environment.
interface ifetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    modport master (
        output imem_addr,
        input  imem_inst,
        input  redirect_valid,
        input  redirect_pc,
        input  stall,
        output inst_valid,
        output inst,
        output inst_pc,
        output fetch_fault
    );

    modport slave (
        input  imem_addr,
        output imem_inst,
        output redirect_valid,
        output redirect_pc,
        output stall,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        input  fetch_fault
    );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch: flopped PC to a sync-read imem, 2-entry credit FIFO.
// Ports: clk, rst (async, active-high), bus (ifetch_unit_if.master):
//   imem_addr/imem_inst memory port, redirect_valid/redirect_pc,
//   stall, inst_valid/inst/inst_pc, fetch_fault.
// Optional: IFETCH_ALIGN_CHECK_EN enables misaligned-redirect FAULT state.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    ifetch_unit_if.master bus
);

    typedef enum logic {RUN, FAULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic        pending_q, pending_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] buf_inst_q [BUF_DEPTH];
    logic [31:0] buf_pc_q   [BUF_DEPTH];

    logic        wr_en;
    logic        pop;
    logic        issue;
    logic [2:0]  occ;
    logic        misalign;
    logic [31:0] tgt;

`ifdef IFETCH_ALIGN_CHECK_EN
    assign misalign        = |bus.redirect_pc[1:0];
    assign tgt             = bus.redirect_pc;
    assign bus.fetch_fault = (state_q == FAULT);
`else
    logic unused_lsbs;
    assign unused_lsbs     = ^bus.redirect_pc[1:0];
    assign misalign        = 1'b0;
    assign tgt             = {bus.redirect_pc[31:2], 2'b00};
    assign bus.fetch_fault = 1'b0;
`endif

    assign bus.imem_addr  = fpc_q;
    assign bus.inst_valid = (count_q != 2'd0);
    assign bus.inst       = buf_inst_q[rd_ptr_q];
    assign bus.inst_pc    = buf_pc_q[rd_ptr_q];

    assign pop = bus.inst_valid && !bus.stall;
    // Words buffered plus the one in flight, after this cycle's pop.
    assign occ = {2'b00, pending_q} + {1'b0, count_q} - {2'b00, pop};

    always_comb begin
        state_d   = state_q;
        fpc_d     = fpc_q;
        pending_d = 1'b0;
        req_pc_d  = req_pc_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        wr_en     = 1'b0;
        issue     = 1'b0;
        unique case (state_q)
            RUN: begin
                if (bus.redirect_valid) begin
                    // Flush buffer and drop the word in flight.
                    wr_ptr_d = 1'b0;
                    rd_ptr_d = 1'b0;
                    count_d  = 2'd0;
                    if (misalign) begin
                        state_d = FAULT;
                    end else begin
                        fpc_d = tgt;
                    end
                end else begin
                    wr_en = pending_q;
                    issue = (occ < 3'd2);
                    if (wr_en) begin
                        wr_ptr_d = ~wr_ptr_q;
                    end
                    if (pop) begin
                        rd_ptr_d = ~rd_ptr_q;
                    end
                    count_d = count_q + {1'b0, wr_en} - {1'b0, pop};
                    if (issue) begin
                        fpc_d     = fpc_q + 32'd4;
                        pending_d = 1'b1;
                        req_pc_d  = fpc_q;
                    end
                end
            end
            FAULT: begin
                wr_ptr_d = 1'b0;
                rd_ptr_d = 1'b0;
                count_d  = 2'd0;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            fpc_q     <= RESET_PC;
            pending_q <= 1'b0;
            req_pc_q  <= 32'd0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            fpc_q     <= fpc_d;
            pending_q <= pending_d;
            req_pc_q  <= req_pc_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_inst_q[i] <= 32'd0;
                buf_pc_q[i]   <= 32'd0;
            end
        end else if (wr_en) begin
            buf_inst_q[wr_ptr_q] <= bus.imem_inst;
            buf_pc_q[wr_ptr_q]   <= req_pc_q;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit; memory model returns addr>>2.
// Checks latency, stall hold, redirect, async reset, misaligned redirect.
module tb_ifetch_unit;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;

    ifetch_unit_if bus ();

    ifetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory: mem[i] = i.
    always @(posedge clk) bus.imem_inst <= bus.imem_addr >> 2;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_pc;
    int          ndel;

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'd0;
        bus.imem_inst = 32'd0;

        #2;
        check("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_pc", bus.inst_pc, 32'd0);
        check("rst_fault", {31'd0, bus.fetch_fault}, 32'd0);
        check("rst_addr", bus.imem_addr, 32'd0);
        #10 rst = 1'b0;

        // Streaming with no stall.
        step();
        check("lat_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("lat_addr", bus.imem_addr, 32'd4);
        for (int k = 0; k < 4; k++) begin
            step();
            check("str_valid", {31'd0, bus.inst_valid}, 32'd1);
            check("str_inst", bus.inst, k);
            check("str_pc", bus.inst_pc, 4 * k);
        end

        // Stall for 5 edges while inst 3 is at the head.
        check("stl_addr0", bus.imem_addr, 32'd20);
        bus.stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("stl_valid", {31'd0, bus.inst_valid}, 32'd1);
            check("stl_inst", bus.inst, 32'd3);
            check("stl_pc", bus.inst_pc, 32'd12);
            check("stl_addr", bus.imem_addr, 32'd20);
        end
        bus.stall = 1'b0;
        for (int k = 4; k < 7; k++) begin
            step();
            check("rel_valid", {31'd0, bus.inst_valid}, 32'd1);
            check("rel_inst", bus.inst, k);
            check("rel_pc", bus.inst_pc, 4 * k);
        end

        // Fill the buffer under stall, then redirect.
        bus.stall = 1'b1;
        step();
        check("full_inst", bus.inst, 32'd6);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h100;
        step();
        bus.redirect_valid = 1'b0;
        check("rd1_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("rd1_addr", bus.imem_addr, 32'h100);
        step();
        check("rd2_valid", {31'd0, bus.inst_valid}, 32'd0);
        step();
        check("rd3_valid", {31'd0, bus.inst_valid}, 32'd1);
        check("rd3_pc", bus.inst_pc, 32'h100);
        check("rd3_inst", bus.inst, 32'h40);
        bus.stall = 1'b0;
        step();
        check("rd4_pc", bus.inst_pc, 32'h104);
        check("rd4_inst", bus.inst, 32'h41);

        // Asynchronous reset mid-stream.
        #3 rst = 1'b1;
        #1;
        check("ar_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("ar_inst", bus.inst, 32'd0);
        check("ar_pc", bus.inst_pc, 32'd0);
        check("ar_addr", bus.imem_addr, 32'd0);
        #3 rst = 1'b0;
        step();
        check("ar1_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("ar1_addr", bus.imem_addr, 32'd4);
        step();
        check("ar2_valid", {31'd0, bus.inst_valid}, 32'd1);
        check("ar2_inst", bus.inst, 32'd0);
        check("ar2_pc", bus.inst_pc, 32'd0);

        // Misaligned redirect.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h102;
        step();
        bus.redirect_valid = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
        check("mis_fault", {31'd0, bus.fetch_fault}, 32'd1);
        check("mis_valid", {31'd0, bus.inst_valid}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("mis_hold_f", {31'd0, bus.fetch_fault}, 32'd1);
            check("mis_hold_v", {31'd0, bus.inst_valid}, 32'd0);
        end
`else
        check("mis_fault", {31'd0, bus.fetch_fault}, 32'd0);
        check("mis_addr", bus.imem_addr, 32'h100);
        check("mis_valid", {31'd0, bus.inst_valid}, 32'd0);
        step();
        step();
        check("mis_v3", {31'd0, bus.inst_valid}, 32'd1);
        check("mis_pc", bus.inst_pc, 32'h100);
        check("mis_inst", bus.inst, 32'h40);
`endif
        #2 rst = 1'b1;
        #1;
        check("rr_fault", {31'd0, bus.fetch_fault}, 32'd0);
        check("rr_valid", {31'd0, bus.inst_valid}, 32'd0);
        #2 rst = 1'b0;
        step();

        // Redirect every other cycle with intermittent stall.
        exp_pc = 32'd0;
        ndel = 0;
        for (int i = 0; i < 26; i++) begin
            if (bus.inst_valid) begin
                check("rr_pc", bus.inst_pc, exp_pc);
                check("rr_inst", bus.inst, exp_pc >> 2);
                if (i >= 20) ndel++;
            end
            if (i < 20) begin
                bus.redirect_valid = (i % 2 == 0);
                bus.redirect_pc = 32'h400 + i * 32'h20;
                bus.stall = (i % 3 == 0);
            end else begin
                bus.redirect_valid = 1'b0;
                bus.stall = 1'b0;
            end
            if (bus.redirect_valid) begin
                exp_pc = bus.redirect_pc;
            end else if (bus.inst_valid && !bus.stall) begin
                exp_pc = exp_pc + 32'd4;
            end
            step();
        end
        check("rr_ndel", ndel, 32'd5);
        check("rr_last", exp_pc, 32'h654);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
